addsum_ctrl: RTL and testbench

//  Sequences the accumulate-sum RAM (sdpram, C_ASIZE x C_DSIZE) as an N-pass read-modify-write accumulator.

---
 rtl/addsum_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_addsum_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsum_ctrl.sv
// addsum_ctrl: N-pass read-modify-write sequencer for the accumulate-sum RAM.
// Pass 0 writes incoming words straight into the RAM. Passes 1..N-1 read the
// partial sum, add the new word and write the result back. The last pass also
// streams the final sums downstream.
// Word pipeline, with I_dv_p2 seen in cycle t:
//   t+1 read issue, t+2 data/rdata aligned + add, t+3 write issue.
// Optional build macro: ADDSUM_SAT_EN selects a signed saturating add in place
// of the default wrap-around add.
module addsum_ctrl #(
  parameter int C_DSIZE   = 32,
  parameter int C_ASIZE   = 10,
  parameter int C_LENSIZE = 9,
  parameter int C_PASSIZE = 8
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic                 I_start,
  input  logic [C_LENSIZE-1:0] I_len,
  input  logic [C_PASSIZE-1:0] I_npass,
  input  logic                 I_dv_p2,
  input  logic                 I_dv,
  input  logic [C_DSIZE-1:0]   I_din,
  output logic                 O_rd,
  output logic [C_ASIZE-1:0]   O_raddr,
  input  logic [C_DSIZE-1:0]   I_rdata,
  output logic                 O_wr,
  output logic [C_ASIZE-1:0]   O_waddr,
  output logic [C_DSIZE-1:0]   O_wdata,
  output logic                 O_sum_dv,
  output logic [C_DSIZE-1:0]   O_sum,
  output logic                 O_busy,
  output logic                 O_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [C_DSIZE-1:0] SUM_MAX = {1'b0, {(C_DSIZE-1){1'b1}}};
  localparam logic [C_DSIZE-1:0] SUM_MIN = {1'b1, {(C_DSIZE-1){1'b0}}};

  state_t               state;

  // job configuration, latched at start (stored as last index)
  logic [C_ASIZE-1:0]   len_m1;
  logic [C_PASSIZE-1:0] npass_m1;

  // read side: address/pass of the next accepted word
  logic [C_ASIZE-1:0]   rptr;
  logic [C_PASSIZE-1:0] rd_pass;
  logic                 rd_end;     // all len*npass words accepted

  // write side: address/pass of the next write; this pass counter owns job end
  logic [C_ASIZE-1:0]   wptr;
  logic [C_PASSIZE-1:0] wr_pass;

  // pipeline tracking
  logic                 s1_vld;     // word in its read-issue cycle
  logic                 s2_vld;     // word in its add cycle
  logic [C_ASIZE-1:0]   s2_addr;

  // previous cycle's write, second bypass entry
  logic                 wr_d;
  logic [C_ASIZE-1:0]   waddr_d;
  logic [C_DSIZE-1:0]   wdata_d;

  logic                 accept;
  logic                 wr_wrap;
  logic                 wr_last_pass;
  logic [C_DSIZE-1:0]   fwd;
  logic [C_DSIZE-1:0]   addend;
  logic [C_DSIZE-1:0]   din_eff;
  logic [C_DSIZE-1:0]   sum;

  assign accept       = (state == RUN) && I_dv_p2 && !rd_end;
  assign wr_wrap      = (wptr == len_m1);
  assign wr_last_pass = (wr_pass == npass_m1);

  // Read-first RAM: the word read in t+1 misses the writes landing in t+1 and
  // t+2, so those two writes are checked newest-first before trusting I_rdata.
  always_comb begin
    fwd = I_rdata;
    if (O_wr && (O_waddr == s2_addr))
      fwd = O_wdata;
    else if (wr_d && (waddr_d == s2_addr))
      fwd = wdata_d;
  end

  // Pass 0 overwrites stale RAM contents; a missing I_dv contributes zero so
  // the pointers stay locked to the I_dv_p2 sequence.
  always_comb begin
    addend  = (wr_pass == '0) ? '0 : fwd;
    din_eff = I_dv ? I_din : '0;
  end

`ifdef ADDSUM_SAT_EN
  logic [C_DSIZE:0] sum_x;

  // Signed saturating add: overflow shows as disagreement of the two top bits.
  always_comb begin
    sum_x = {addend[C_DSIZE-1], addend} + {din_eff[C_DSIZE-1], din_eff};
    sum   = sum_x[C_DSIZE-1:0];
    if (sum_x[C_DSIZE] != sum_x[C_DSIZE-1])
      sum = sum_x[C_DSIZE] ? SUM_MIN : SUM_MAX;
  end
`else
  // Plain modulo-2^C_DSIZE add; the saturation limits are unused here.
  always_comb begin
    sum = addend + din_eff;
    if (SUM_MAX == SUM_MIN) sum = '0;
  end
`endif

  // Control FSM, pointers, pipeline and all registered outputs.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state    <= IDLE;
      len_m1   <= '0;
      npass_m1 <= '0;
      rptr     <= '0;
      rd_pass  <= '0;
      rd_end   <= 1'b0;
      wptr     <= '0;
      wr_pass  <= '0;
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      s2_addr  <= '0;
      wr_d     <= 1'b0;
      waddr_d  <= '0;
      wdata_d  <= '0;
      O_rd     <= 1'b0;
      O_raddr  <= '0;
      O_wr     <= 1'b0;
      O_waddr  <= '0;
      O_wdata  <= '0;
      O_sum_dv <= 1'b0;
      O_sum    <= '0;
      O_busy   <= 1'b0;
      O_done   <= 1'b0;
    end else begin
      O_rd     <= 1'b0;
      O_wr     <= 1'b0;
      O_sum_dv <= 1'b0;
      O_done   <= 1'b0;
      s1_vld   <= accept;
      s2_vld   <= s1_vld;
      wr_d     <= O_wr;
      waddr_d  <= O_waddr;
      wdata_d  <= O_wdata;

      // stage 1: issue the read (never on pass 0) and step the read pointer
      if (accept) begin
        O_rd    <= (rd_pass != '0);
        O_raddr <= rptr;
        if (rptr == len_m1) begin
          rptr <= '0;
          if (rd_pass == npass_m1) rd_end  <= 1'b1;
          else                     rd_pass <= rd_pass + C_PASSIZE'(1);
        end else begin
          rptr <= rptr + C_ASIZE'(1);
        end
      end

      if (s1_vld) s2_addr <= O_raddr;

      // stage 2: register the sum as a write; the wrap of the last pass ends the job
      if (s2_vld) begin
        O_wr    <= 1'b1;
        O_waddr <= wptr;
        O_wdata <= sum;
        if (wr_last_pass) begin
          O_sum_dv <= 1'b1;
          O_sum    <= sum;
        end
        if (wr_wrap) begin
          wptr <= '0;
          if (wr_last_pass) begin
            state  <= DONE;
            O_done <= 1'b1;
          end else begin
            wr_pass <= wr_pass + C_PASSIZE'(1);
          end
        end else begin
          wptr <= wptr + C_ASIZE'(1);
        end
      end

      case (state)
        IDLE: begin
          if (I_start) begin
            len_m1   <= C_ASIZE'(I_len) - C_ASIZE'(1);
            npass_m1 <= I_npass - C_PASSIZE'(1);
            rptr     <= '0;
            rd_pass  <= '0;
            rd_end   <= 1'b0;
            wptr     <= '0;
            wr_pass  <= '0;
            O_busy   <= 1'b1;
            if ((I_len == '0) || (I_npass == '0)) begin
              state  <= DONE;
              O_done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          O_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsum_ctrl.sv
// Bench for addsum_ctrl: directed T1..T5 scenarios followed by random jobs.
// A read-first RAM fixture sits on the RAM ports; expected sums come from
// per-address accumulation of the stimulus words.
module tb_addsum_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 9;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          I_start = 1'b0;
  logic [LW-1:0] I_len = '0;
  logic [PW-1:0] I_npass = '0;
  logic          I_dv_p2 = 1'b0;
  logic          I_dv = 1'b0;
  logic [DW-1:0] I_din = '0;
  logic          O_rd;
  logic [AW-1:0] O_raddr;
  logic [DW-1:0] I_rdata = '0;
  logic          O_wr;
  logic [AW-1:0] O_waddr;
  logic [DW-1:0] O_wdata;
  logic          O_sum_dv;
  logic [DW-1:0] O_sum;
  logic          O_busy;
  logic          O_done;

  always #5 clk = ~clk;

  addsum_ctrl #(.C_DSIZE(DW), .C_ASIZE(AW), .C_LENSIZE(LW), .C_PASSIZE(PW)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(I_start), .I_len(I_len), .I_npass(I_npass),
    .I_dv_p2(I_dv_p2), .I_dv(I_dv), .I_din(I_din),
    .O_rd(O_rd), .O_raddr(O_raddr), .I_rdata(I_rdata),
    .O_wr(O_wr), .O_waddr(O_waddr), .O_wdata(O_wdata),
    .O_sum_dv(O_sum_dv), .O_sum(O_sum), .O_busy(O_busy), .O_done(O_done)
  );

  // read-first synchronous RAM fixture
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (O_rd) I_rdata <= ram[O_raddr];
    if (O_wr) ram[O_waddr] <= O_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor
  int            rd_cnt, wr_cnt, done_cnt, done_cyc;
  logic [DW-1:0] sum_q[$];
  logic [DW-1:0] wd_q[$];
  logic [AW-1:0] wa_q[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (O_rd) rd_cnt++;
      if (O_wr) begin wr_cnt++; wa_q.push_back(O_waddr); wd_q.push_back(O_wdata); end
      if (O_sum_dv) sum_q.push_back(O_sum);
      if (O_done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] madd(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef ADDSUM_SAT_EN
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
`else
    return a + b;
`endif
  endfunction

  task automatic clear_mon();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    sum_q.delete(); wd_q.delete(); wa_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, {59'd0, O_rd, O_wr, O_sum_dv, O_busy, O_done}, 64'd0);
    check({tag, "_addr"}, {44'd0, O_raddr, O_waddr}, 64'd0);
    check({tag, "_data"}, {O_wdata, O_sum}, 64'd0);
  endtask

  logic [DW-1:0] stim[$];

  // Runs one job over stim. gapw: idle-cycle odds between I_dv_p2 pulses,
  // extra: surplus I_dv_p2 beyond len*npass, abort_at: assert reset after that
  // many pulses (0 = never), poke: pulse I_start mid-job, start_done: pulse
  // I_start in the cycle of the last write.
  task automatic run_job(input int len, input int npass, input int gapw, input int extra,
                         input int abort_at, input bit poke, input bit start_done);
    int total, sent, fired_last, nwait;
    bit hv0, hv1, f;
    logic [DW-1:0] hd0, hd1;
    logic [DW-1:0] expv[$];
    total = len * npass;
    sent = 0; fired_last = -1; hv0 = 0; hv1 = 0; hd0 = '0; hd1 = '0;
    clear_mon();
    @(negedge clk);
    I_start = 1'b1; I_len = LW'(len); I_npass = PW'(npass);
    @(negedge clk);
    I_start = 1'b0;
    while ((sent < total + extra) || hv0 || hv1) begin
      f = (sent < total + extra) && ($urandom_range(0, gapw) == 0);
      I_dv  = hv1;
      I_din = hv1 ? hd1 : $urandom;
      hv1 = hv0; hd1 = hd0;
      hv0 = f;   hd0 = (sent < total) ? stim[sent] : $urandom;
      I_dv_p2 = f;
      I_start = poke && (sent == 1);
      if (poke && sent == 1) begin I_len = 3; I_npass = 1; end
      if (f) begin
        if (sent == total - 1) fired_last = cyc;
        sent++;
      end
      if (abort_at > 0 && sent == abort_at) begin
        @(negedge clk);
        rst_n = 1'b0;
        I_dv_p2 = 1'b0; I_dv = 1'b0; I_din = '0; I_start = 1'b0;
        #1;
        check_idle_outputs("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    I_dv_p2 = 1'b0; I_dv = 1'b0; I_start = 1'b0;
    if (start_done) begin
      // loop exit lands on the cycle carrying the final write and O_done
      I_start = 1'b1; I_len = 2; I_npass = 1;
      @(negedge clk);
      I_start = 1'b0;
    end
    repeat (4) @(negedge clk);
    nwait = 0;
    while (done_cnt == 0 && nwait < 200) begin @(negedge clk); nwait++; end
    check("done_seen", 64'(done_cnt), 64'd1);
    check("done_latency", 64'(done_cyc - fired_last), 64'd3);
    check("busy_after", {63'd0, O_busy}, 64'd0);
    check("rd_count", 64'(rd_cnt), 64'(len * (npass - 1)));
    check("wr_count", 64'(wr_cnt), 64'(total));
    // expected final sums: per-address accumulation across passes
    for (int a = 0; a < len; a++) begin
      logic [DW-1:0] acc;
      acc = stim[a];
      for (int p = 1; p < npass; p++) acc = madd(acc, stim[p * len + a]);
      expv.push_back(acc);
    end
    check("sum_count", 64'(sum_q.size()), 64'(len));
    for (int a = 0; a < len && a < sum_q.size(); a++) begin
      check("final_sum", {32'd0, sum_q[a]}, {32'd0, expv[a]});
      check("final_addr", 64'(wa_q[total - len + a]), 64'(a));
    end
  endtask

  task automatic fill_stim(input int n, input bit edgy);
    stim.delete();
    for (int i = 0; i < n; i++) begin
      case (edgy ? $urandom_range(0, 3) : 0)
        1: stim.push_back(32'h7FFF_FFF0 + 32'($urandom_range(0, 31)));
        2: stim.push_back(32'h8000_0000 + 32'($urandom_range(0, 31)));
        3: stim.push_back(32'($urandom_range(0, 15)));
        default: stim.push_back($urandom);
      endcase
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int len, npass;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: single pass writes words directly, no reads
    stim = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_job(4, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      check("t1_waddr", 64'(wa_q[i]), 64'(i));
      check("t1_wdata", {32'd0, wd_q[i]}, 64'(i + 1));
    end

    // T2: three passes of 10
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(32'd10);
    run_job(4, 3, 0, 0, 0, 0, 0);
    check("t2_sum0", {32'd0, sum_q.size() > 0 ? sum_q[0] : 32'd0}, 64'd30);

    // T3: len=1 back-to-back relies on the bypass
    stim = '{32'd5, 32'd5, 32'd5, 32'd5};
    run_job(1, 4, 0, 0, 0, 0, 0);
    check("t3_sum", {32'd0, sum_q.size() > 0 ? sum_q[0] : 32'd0}, 64'd20);

    // T4: overflow boundary
    stim = '{32'h7FFF_FFFF, 32'h0000_0001};
    run_job(1, 2, 0, 0, 0, 0, 0);
`ifdef ADDSUM_SAT_EN
    check("t4_sum", {32'd0, sum_q.size() > 0 ? sum_q[0] : 32'd0}, 64'h7FFF_FFFF);
`else
    check("t4_sum", {32'd0, sum_q.size() > 0 ? sum_q[0] : 32'd0}, 64'h8000_0000);
`endif

    // T5a: zero-length and zero-pass jobs finish at once without RAM access
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      @(negedge clk);
      I_start = 1'b1; I_len = (k == 0) ? LW'(0) : LW'(5); I_npass = (k == 0) ? PW'(3) : PW'(0);
      @(negedge clk);
      I_start = 1'b0;
      check("t5_done_now", {62'd0, O_done, O_busy}, 64'd3);
      @(negedge clk);
      check("t5_done_end", {62'd0, O_done, O_busy}, 64'd0);
      check("t5_no_ram", 64'(rd_cnt + wr_cnt), 64'd0);
    end

    // T5b: reset mid-pass, then a fresh job of the same shape
    fill_stim(16, 0);
    run_job(8, 2, 0, 0, 10, 0, 0);
    @(negedge clk);
    check_idle_outputs("post_reset");
    fill_stim(16, 0);
    run_job(8, 2, 1, 0, 0, 0, 0);

    // last write coinciding with I_start: start must be dropped
    fill_stim(6, 0);
    run_job(3, 2, 0, 0, 0, 0, 1);
    check("start_at_done_wr", 64'(wr_cnt), 64'd6);

    // random jobs: gaps, surplus pulses, mid-job start pokes, edge values
    for (int j = 0; j < 10; j++) begin
      len   = $urandom_range(1, 6);
      npass = $urandom_range(1, 4);
      fill_stim(len * npass, 1);
      run_job(len, npass, $urandom_range(0, 2), $urandom_range(0, 3), 0,
              (len * npass) >= 4, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
